rf_dump_reader: RTL and testbench

- Read-side initiator for the integer register file (NREGS architectural registers, x0 hard-wired to zero).
- On a start request, walks every register through one regfile read port.
- Streams each (index, value) pair out over a valid/ready interface to the debug/difftest bridge.
- Snoops the writeback port and flags whether the dump went stale while it was in progress.

---
 rtl/rf_dump_reader_pkg.sv | 15 +
 rtl/rf_dump_beat_reg.sv | 61 ++++++
 rtl/rf_dump_reader.sv | 112 +++++++++++
 tb/tb_rf_dump_reader.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/rf_dump_reader_pkg.sv
// rtl/rf_dump_reader_pkg.sv - shared register-file geometry and dump FSM state type
package rf_dump_reader_pkg;

    localparam int NREGS_RV32E = 16;
    localparam int REG_AW      = 5;
    localparam int REG_DW      = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        SEND = 2'd2,
        DONE = 2'd3
    } dump_state_e;

endpackage

// File: rtl/rf_dump_beat_reg.sv
// rtl/rf_dump_beat_reg.sv - output holding register for one (index, value) dump beat
module rf_dump_beat_reg
    import rf_dump_reader_pkg::*;
#(
    parameter int AW = REG_AW,
    parameter int DW = REG_DW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load_i,
    input  logic [AW-1:0] idx_i,
    input  logic [DW-1:0] data_i,
    input  logic          last_i,
    input  logic          ready_i,
    output logic          valid_o,
    output logic [AW-1:0] idx_o,
    output logic [DW-1:0] data_o,
    output logic          last_o
);

    logic          valid_q, valid_d;
    logic [AW-1:0] idx_q, idx_d;
    logic [DW-1:0] data_q, data_d;
    logic          last_q, last_d;

    // Payload only changes on load, so it stays frozen under backpressure.
    always_comb begin
        valid_d = valid_q;
        idx_d   = idx_q;
        data_d  = data_q;
        last_d  = last_q;
        if (load_i) begin
            valid_d = 1'b1;
            idx_d   = idx_i;
            data_d  = data_i;
            last_d  = last_i;
        end else if (valid_q && ready_i) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            idx_q   <= '0;
            data_q  <= '0;
            last_q  <= 1'b0;
        end else begin
            valid_q <= valid_d;
            idx_q   <= idx_d;
            data_q  <= data_d;
            last_q  <= last_d;
        end
    end

    assign valid_o = valid_q;
    assign idx_o   = idx_q;
    assign data_o  = data_q;
    assign last_o  = last_q;

endmodule

// File: rtl/rf_dump_reader.sv
// rtl/rf_dump_reader.sv - walks the integer regfile and streams (index, value) beats with stale-dump detection
module rf_dump_reader
    import rf_dump_reader_pkg::*;
#(
    parameter int NREGS = NREGS_RV32E,
    parameter int AW    = REG_AW,
    parameter int DW    = REG_DW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    output logic          busy,
    output logic [AW-1:0] rf_raddr,
    input  logic [DW-1:0] rf_rdata,
    input  logic          wb_wen,
    input  logic [AW-1:0] wb_waddr,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [AW-1:0] out_idx,
    output logic [DW-1:0] out_data,
    output logic          out_last,
    output logic          done,
    output logic          dirty
);

    localparam logic [AW-1:0] LAST_IDX = AW'(NREGS - 1);

    dump_state_e   state_q, state_d;
    logic [AW-1:0] idx_q, idx_d;
    logic          dirty_q, dirty_d;
    logic          beat_load;
    logic          snoop_hit;

    // A write to the register being loaded right now is not stale: the read
    // sees the old value and the new one belongs to the next dump.
    assign snoop_hit = wb_wen && (wb_waddr != '0) && (wb_waddr <= LAST_IDX) &&
                       ((wb_waddr < idx_q) || ((wb_waddr == idx_q) && (state_q != LOAD)));

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        dirty_d   = dirty_q;
        beat_load = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    idx_d   = '0;
                    dirty_d = 1'b0;
                    state_d = LOAD;
                end
            end
            LOAD: begin
                beat_load = 1'b1;
                state_d   = SEND;
            end
            SEND: begin
                if (out_valid && out_ready) begin
                    if (out_last) begin
                        state_d = DONE;
                    end else begin
                        idx_d   = idx_q + AW'(1);
                        state_d = LOAD;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        if ((state_q != IDLE) && snoop_hit) begin
            dirty_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            dirty_q <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            dirty_q <= dirty_d;
        end
    end

    rf_dump_beat_reg #(
        .AW (AW),
        .DW (DW)
    ) u_beat (
        .clk     (clk),
        .rst     (rst),
        .load_i  (beat_load),
        .idx_i   (idx_q),
        .data_i  ((idx_q == '0) ? '0 : rf_rdata),
        .last_i  (idx_q == LAST_IDX),
        .ready_i (out_ready),
        .valid_o (out_valid),
        .idx_o   (out_idx),
        .data_o  (out_data),
        .last_o  (out_last)
    );

    assign rf_raddr = (state_q == IDLE) ? '0 : idx_q;
    assign busy     = (state_q != IDLE);
    assign done     = (state_q == DONE);
    assign dirty    = dirty_q;

endmodule

// File: tb/tb_rf_dump_reader.sv
// tb/tb_rf_dump_reader.sv - self-checking bench for rf_dump_reader
module tb_rf_dump_reader;

    localparam int N  = 16;
    localparam int AW = 5;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst, start, wb_wen, out_ready;
    logic [AW-1:0] rf_raddr, wb_waddr, out_idx;
    logic [DW-1:0] rf_rdata, out_data, wb_wdata;
    logic          busy, out_valid, out_last, done, dirty;

    logic [DW-1:0] rf_mem [0:31];

    int checks = 0;
    int errs   = 0;

    int            wb_addr_at [0:63];
    logic [DW-1:0] wb_dat_at  [0:63];
    bit            captured   [0:N-1];
    logic [DW-1:0] exp_data   [0:N-1];
    bit            exp_dirty;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (wb_wen && wb_waddr != '0) rf_mem[wb_waddr] <= wb_wdata;
    end
    assign rf_rdata = (rf_raddr == '0) ? 32'hDEADBEEF : rf_mem[rf_raddr];

    rf_dump_reader dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .busy      (busy),
        .rf_raddr  (rf_raddr),
        .rf_rdata  (rf_rdata),
        .wb_wen    (wb_wen),
        .wb_waddr  (wb_waddr),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_idx   (out_idx),
        .out_data  (out_data),
        .out_last  (out_last),
        .done      (done),
        .dirty     (dirty)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errs++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Cycle (relative to the start cycle) in which register i is read.
    function automatic int load_cyc(int i, int si, int sl);
        return 1 + 2 * i + ((i > si) ? sl : 0);
    endfunction

    function automatic int beat_at(int k, int si, int sl);
        for (int i = 0; i < N; i++) begin
            int vs, ve;
            vs = load_cyc(i, si, sl) + 1;
            ve = vs + ((i == si) ? sl : 0);
            if (k >= vs && k <= ve) return i;
        end
        return -1;
    endfunction

    task automatic clear_wb();
        for (int c = 0; c < 64; c++) begin
            wb_addr_at[c] = -1;
            wb_dat_at[c]  = '0;
        end
    endtask

    task automatic preload(input bit seq);
        for (int i = 0; i < 32; i++) rf_mem[i] = seq ? (32'h1000 + 32'(i)) : $urandom;
    endtask

    task automatic drive_wb(input int k, input int done_c);
        int a;
        a = wb_addr_at[k];
        if (a >= 0) begin
            wb_wen   = 1'b1;
            wb_waddr = AW'(a);
            wb_wdata = wb_dat_at[k];
            if (k >= 1 && k < done_c && a >= 1 && a < N && captured[a]) exp_dirty = 1'b1;
        end else begin
            wb_wen = 1'b0;
        end
    endtask

    // si/sl: stall beat and stall length; bs_cyc: start pulse while busy; rst_cyc: abort cycle (0 = none)
    task automatic run_dump(input string tag, input int si, input int sl, input int bs_cyc, input int rst_cyc);
        int done_c, stall_lo, stall_hi, b;
        logic [63:0] exp_beat;
        done_c   = 2 * N + 1 + sl;
        stall_lo = load_cyc(si, si, sl) + 1;
        stall_hi = stall_lo + sl - 1;
        exp_dirty = 1'b0;
        for (int i = 0; i < N; i++) captured[i] = 1'b0;
        @(negedge clk);
        start = 1'b1;
        drive_wb(0, done_c);
        for (int k = 1; k <= done_c + 2; k++) begin
            @(negedge clk);
            if (rst_cyc > 0 && k == rst_cyc + 1) begin
                chk({tag, " abort valid"}, 64'(out_valid), 64'(0));
                chk({tag, " abort busy"}, 64'(busy), 64'(0));
                rst = 1'b0;
                wb_wen = 1'b0;
                start = 1'b0;
                out_ready = 1'b1;
                for (int j = 0; j < 4; j++) begin
                    @(negedge clk);
                    chk({tag, " abort no done"}, 64'({done, busy, out_valid}), 64'(0));
                end
                return;
            end
            b = beat_at(k, si, sl);
            chk({tag, " valid"}, 64'(out_valid), 64'(b >= 0));
            if (b >= 0) begin
                exp_beat = {26'b0, AW'(b), (b == N - 1), exp_data[b]};
                chk({tag, " beat"}, {26'b0, out_idx, out_last, out_data}, exp_beat);
            end
            chk({tag, " done"}, 64'(done), 64'(k == done_c));
            chk({tag, " busy"}, 64'(busy), 64'(k <= done_c));
            if (k >= done_c) chk({tag, " dirty"}, 64'(dirty), 64'(exp_dirty));
            start     = (k == bs_cyc);
            rst       = (k == rst_cyc);
            out_ready = !(k >= stall_lo && k <= stall_hi);
            for (int i = 0; i < N; i++) begin
                if (k == load_cyc(i, si, sl)) begin
                    chk({tag, " raddr"}, 64'(rf_raddr), 64'(i));
                    exp_data[i] = (i == 0) ? '0 : rf_mem[i];
                end
            end
            if (k <= done_c) drive_wb(k, done_c);
            else wb_wen = 1'b0;
            for (int i = 0; i < N; i++) begin
                if (k == load_cyc(i, si, sl)) captured[i] = 1'b1;
            end
        end
        start = 1'b0;
        wb_wen = 1'b0;
        out_ready = 1'b1;
    endtask

    initial begin
        int si, sl, dc, nw;
        rst = 1'b1; start = 1'b0; wb_wen = 1'b0; wb_waddr = '0; wb_wdata = '0; out_ready = 1'b1;
        preload(1'b1);
        clear_wb();
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset outputs", {busy, out_valid, out_idx, out_data, out_last, done, dirty, rf_raddr}, 64'(0));
        rst = 1'b0;
        @(negedge clk);
        chk("idle after reset", {busy, out_valid, done, dirty, rf_raddr}, 64'(0));

        run_dump("plain", -1, 0, 0, 0);

        preload(1'b0);
        run_dump("stall", 3, 5, 0, 0);

        preload(1'b1);
        clear_wb();
        wb_addr_at[16] = 2; wb_dat_at[16] = 32'h55;
        run_dump("wb behind", -1, 0, 0, 0);
        @(negedge clk);
        chk("dirty held in idle", 64'(dirty), 64'(1));

        preload(1'b1);
        clear_wb();
        wb_addr_at[16] = 9; wb_dat_at[16] = 32'h55;
        run_dump("wb ahead", -1, 0, 0, 0);

        preload(1'b1);
        clear_wb();
        wb_addr_at[9]  = 4;  wb_dat_at[9]  = 32'hAAAA;
        wb_addr_at[12] = 0;  wb_dat_at[12] = $urandom;
        wb_addr_at[20] = 28; wb_dat_at[20] = $urandom;
        wb_addr_at[25] = 16; wb_dat_at[25] = $urandom;
        run_dump("same cycle", -1, 0, 0, 0);

        preload(1'b0);
        clear_wb();
        run_dump("busy start", -1, 0, 11, 0);

        preload(1'b0);
        wb_addr_at[5] = 1; wb_dat_at[5] = $urandom;
        run_dump("abort", -1, 0, 0, 17);

        preload(1'b1);
        clear_wb();
        run_dump("restart", -1, 0, 0, 0);

        for (int r = 0; r < 6; r++) begin
            preload(1'b0);
            clear_wb();
            si = $urandom_range(0, N - 1);
            sl = $urandom_range(0, 4);
            dc = 2 * N + 1 + sl;
            nw = $urandom_range(1, 5);
            for (int w = 0; w < nw; w++) begin
                int c;
                c = $urandom_range(0, dc - 1);
                wb_addr_at[c] = $urandom_range(0, 31);
                wb_dat_at[c]  = $urandom;
            end
            run_dump("random", si, sl, 0, 0);
        end

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
